jts16_obj_zdraw: RTL and testbench
==================================

# jts16_obj_zdraw

Parametrised sprite line drawer for the System 16 / OutRun object pipeline, placed between the object scan engine and the line buffer. It fetches packed pixel words from object ROM through the SDRAM slot handshake. It applies fixed-point horizontal zoom and writes non-transparent pixels into the line buffer, either forward or backward. Over the current OutRun drawer it adds configurable widths, run-time clip limits, a completion pulse and a sticky late flag.

## Interface
- DW, 32, ROM word width; multiple of PW
- PW, 4, bits per pixel; NPX = DW/PW pixels per word
- AW, 9, line buffer address width
- RAW, 18, ROM word address width
- ZW, 10, zoom input width; accumulator is ZW+3 bits
- ZONE, 512, zoom unity step
- PALW, 7, palette field width
- rst  in  1  reset, asynchronous, active-high
- clk  in  1  clock
- hstart  in  1  line start; aborts any draw
- start  in  1  one-cycle draw request; attributes valid this cycle
- busy  out  1  draw in progress
- done  out  1  one-cycle pulse on normal completion
- late  out  1  sticky; set when hstart aborts a busy draw, cleared by start
- xpos  in  AW  first buffer address
- addr  in  RAW  first ROM word address
- prio  in  2  priority; shadow  in  1  shadow flag; pal  in  PALW  palette
- hzoom  in  ZW  zoom step; ZONE = 1:1, smaller values enlarge
- hflip  in  1  pixel order LSB-first and ROM address decrements
- backwd  in  1  buffer address decrements
- xmin, xmax  in  AW  inclusive clip limits
- rom_ok  in  1  rom_data valid; rom_cs  out  1; rom_addr  out  RAW; rom_data  in  DW
- bf_we  out  1; bf_addr  out  AW; bf_data  out  PALW+3+PW = {pal, shadow, prio, pixel}

## Operation
- States: IDLE, FETCH, DRAW.
- IDLE, start: latch all attributes. rom_addr=addr, bf_addr=xpos, acc=0, pix=0, late=0. Go to FETCH with rom_cs=1.
- FETCH: hold rom_cs=1 and rom_addr until rom_ok=1. Latch rom_data, drop rom_cs, go to DRAW.
- Current pixel: hflip=0 takes the top PW bits and shifts left by PW per advance. hflip=1 takes the bottom PW bits and shifts right.
- DRAW, each cycle exactly one action:
  - acc<ZONE, draw step: bf_we=1 unless the pixel is 0 (transparent). acc+=hzoom, then bf_addr ±1 (backwd selects −1).
  - Clip stop: if the address just drawn equals xmax (forward) or xmin (backward), go to IDLE and pulse done. The buffer address wraps modulo 2^AW only when the limit is never hit.
  - acc≥ZONE, advance step: acc−=ZONE, pix+=1, no write.
  - After an advance past pixel NPX−1: rom_addr ±1 (hflip selects −1), go to FETCH.
- End marker: a pixel of all ones, reached in DRAW, ends the draw. Never written. Go to IDLE and pulse done.
- hzoom=0: the current pixel repeats until the clip limit.
- hstart in any state: rom_cs=0, bf_we=0, go to IDLE. If busy, late=1 and done is not pulsed.
- hstart and start in the same cycle: hstart wins and start is dropped.
- start while busy: restart from the new attributes; the old draw is abandoned without done.

## Timing
- Reset values: busy=0, done=0, late=0, rom_cs=0, rom_addr=0, bf_we=0, bf_addr=0, bf_data=0.
- start at cycle N: rom_cs=1 and busy=1 at N+1.
- rom_ok high at cycle M: first DRAW cycle, and first possible bf_we, at M+1.
- At hzoom=ZONE the drawer spends 2 cycles per pixel (draw + advance).
- Each word costs at least 1 FETCH cycle plus the SDRAM wait.
- bf_we, bf_addr and bf_data are registered and change together; bf_addr is the address being written.
- done is asserted in the cycle busy falls.
- rom_addr is stable whenever rom_cs=1. rom_data is sampled only in a cycle with rom_cs=1 and rom_ok=1.

## Test plan
- Forward draw, DW=32, hzoom=0x200, xpos=0x100, word 0x12345670 then 0xF0000000:
  - writes pixels 1..7 at 0x100..0x106, skips 0x107;
  - second word terminates the draw with no write;
  - done pulses once.
- hflip=1, addr=0x0010, word 0x0765432F:
  - pixel order is F first, so the draw ends immediately with zero writes;
  - rom_addr is never 0x000F.
- hzoom=0x100, backwd=1, xpos=0x120, xmin=0x11C, word 0x11111111:
  - each pixel is written twice at 0x120, 0x11F, …;
  - writes stop after 0x11C, then busy=0 and done=1.
- rom_ok held low for 20 cycles: rom_cs and rom_addr are stable, there are no writes, and the draw proceeds once rom_ok=1.
- hstart mid-draw: busy=0, rom_cs=0 and late=1 next cycle, no done. The next start clears late.
- Reset asserted mid-FETCH: every output returns to its reset value at once. A start after reset release draws normally.

Source files
------------

// File: rtl/jts16_obj_zdraw.sv
// jts16_obj_zdraw -- sprite line drawer for the System 16 / OutRun object path.
//
// It fetches packed pixel words from object ROM through the SDRAM slot
// handshake. It steps through the pixels with a fixed-point horizontal zoom
// accumulator. Every non-transparent pixel is written into the line buffer,
// walking the buffer address forward or backward.
//
// Ports
//   rst, clk        asynchronous active-high reset, clock
//   hstart          line start; aborts any draw (sets late if one was running)
//   start           one-cycle draw request; attributes sampled in that cycle
//   busy/done/late  draw in progress / completion pulse / sticky abort flag
//   xpos, addr      first line-buffer address / first ROM word address
//   prio, shadow,
//   pal             attributes packed into every buffer write
//   hzoom           accumulator step per drawn pixel (ZONE = 1:1)
//   hflip           LSB-first pixel order, ROM address decrements
//   backwd          buffer address decrements
//   xmin, xmax      inclusive clip limits (xmax forward, xmin backward)
//   rom_*           ROM slot: rom_cs/rom_addr request, rom_ok/rom_data reply
//   bf_*            registered line-buffer write port; bf_data = {pal,shadow,prio,pixel}
//   dbg_state       current FSM state (0 idle, 1 fetch, 2 draw)
//
// Handshake: a ROM request is open while rom_cs=1. rom_addr is held stable
// during the whole request. The word is taken in the first cycle with
// rom_cs=1 and rom_ok=1, and rom_cs drops in the following cycle.
module jts16_obj_zdraw #(
  parameter int DW   = 32,
  parameter int PW   = 4,
  parameter int AW   = 9,
  parameter int RAW  = 18,
  parameter int ZW   = 10,
  parameter int ZONE = 512,
  parameter int PALW = 7
)(
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   hstart,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   late,
  input  logic [AW-1:0]          xpos,
  input  logic [RAW-1:0]         addr,
  input  logic [1:0]             prio,
  input  logic                   shadow,
  input  logic [PALW-1:0]        pal,
  input  logic [ZW-1:0]          hzoom,
  input  logic                   hflip,
  input  logic                   backwd,
  input  logic [AW-1:0]          xmin,
  input  logic [AW-1:0]          xmax,
  input  logic                   rom_ok,
  output logic                   rom_cs,
  output logic [RAW-1:0]         rom_addr,
  input  logic [DW-1:0]          rom_data,
  output logic                   bf_we,
  output logic [AW-1:0]          bf_addr,
  output logic [PALW+3+PW-1:0]   bf_data,
  output logic [1:0]             dbg_state
);

  localparam int NPX  = DW / PW;
  localparam int PIXW = (NPX > 1) ? $clog2(NPX) : 1;
  localparam int ACCW = ZW + 3;
  localparam logic [ACCW-1:0] ZONE_A  = ACCW'(ZONE);
  localparam logic [PIXW-1:0] LAST_PX = PIXW'(NPX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Attributes latched at start
  logic [1:0]      prio_q;
  logic            shadow_q;
  logic [PALW-1:0] pal_q;
  logic [ZW-1:0]   hzoom_q;
  logic            hflip_q;
  logic            backwd_q;
  logic [AW-1:0]   xmin_q;
  logic [AW-1:0]   xmax_q;

  // Datapath
  logic [DW-1:0]   word_q;   // shifted so the current pixel sits at one end
  logic [ACCW-1:0] acc_q;
  logic [PIXW-1:0] pix_q;
  logic [AW-1:0]   pos_q;    // next buffer address to draw

  // Decode
  logic [PW-1:0]   cur_pix;
  logic            end_mark;
  logic            draw_step;
  logic            adv_step;
  logic            clip_hit;
  logic            word_end;
  logic [AW-1:0]   limit;

  always_comb begin
    cur_pix   = hflip_q ? word_q[PW-1:0] : word_q[DW-1 -: PW];
    end_mark  = &cur_pix;
    limit     = backwd_q ? xmin_q : xmax_q;
    draw_step = 1'b0;
    adv_step  = 1'b0;
    if (state_q == ST_DRAW && !end_mark) begin
      draw_step = (acc_q < ZONE_A);
      adv_step  = !(acc_q < ZONE_A);
    end
    clip_hit  = draw_step && (pos_q == limit);
    word_end  = adv_step && (pix_q == LAST_PX);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: hstart beats start, start beats everything else
  always_comb begin
    state_d = state_q;
    if (hstart) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: if (rom_ok) state_d = ST_DRAW;
        ST_DRAW: begin
          if (end_mark || clip_hit) state_d = ST_IDLE;
          else if (word_end)        state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    rom_cs    = (state_q == ST_FETCH);
    dbg_state = state_q;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q   <= '0;
      shadow_q <= 1'b0;
      pal_q    <= '0;
      hzoom_q  <= '0;
      hflip_q  <= 1'b0;
      backwd_q <= 1'b0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      word_q   <= '0;
      acc_q    <= '0;
      pix_q    <= '0;
      pos_q    <= '0;
      rom_addr <= '0;
      bf_we    <= 1'b0;
      bf_addr  <= '0;
      bf_data  <= '0;
      done     <= 1'b0;
      late     <= 1'b0;
    end else begin
      bf_we <= 1'b0;
      done  <= 1'b0;
      if (hstart) begin
        if (busy) late <= 1'b1;
      end else if (start) begin
        prio_q   <= prio;
        shadow_q <= shadow;
        pal_q    <= pal;
        hzoom_q  <= hzoom;
        hflip_q  <= hflip;
        backwd_q <= backwd;
        xmin_q   <= xmin;
        xmax_q   <= xmax;
        rom_addr <= addr;
        bf_addr  <= xpos;
        pos_q    <= xpos;
        acc_q    <= '0;
        pix_q    <= '0;
        late     <= 1'b0;
      end else begin
        case (state_q)
          ST_FETCH: if (rom_ok) word_q <= rom_data;
          ST_DRAW: begin
            if (end_mark) begin
              done <= 1'b1;
            end else if (draw_step) begin
              bf_we   <= |cur_pix;
              bf_addr <= pos_q;
              bf_data <= {pal_q, shadow_q, prio_q, cur_pix};
              acc_q   <= acc_q + ACCW'(hzoom_q);
              pos_q   <= backwd_q ? pos_q - AW'(1) : pos_q + AW'(1);
              if (clip_hit) done <= 1'b1;
            end else begin
              acc_q <= acc_q - ZONE_A;
              if (pix_q == LAST_PX) begin
                pix_q    <= '0;
                rom_addr <= hflip_q ? rom_addr - RAW'(1) : rom_addr + RAW'(1);
              end else begin
                pix_q  <= pix_q + PIXW'(1);
                word_q <= hflip_q ? (word_q >> PW) : (word_q << PW);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jts16_obj_zdraw.sv
module tb_jts16_obj_zdraw;

  localparam int DW = 32, PW = 4, AW = 9, RAW = 18, ZW = 10, PALW = 7;
  localparam int BW = PALW + 3 + PW;
  localparam int WW = AW + BW;

  logic            rst, clk, hstart, start;
  logic            busy, done, late;
  logic [AW-1:0]   xpos, xmin, xmax;
  logic [RAW-1:0]  addr;
  logic [1:0]      prio;
  logic            shadow;
  logic [PALW-1:0] pal;
  logic [ZW-1:0]   hzoom;
  logic            hflip, backwd;
  logic            rom_ok, rom_cs;
  logic [RAW-1:0]  rom_addr;
  logic [DW-1:0]   rom_data;
  logic            bf_we;
  logic [AW-1:0]   bf_addr;
  logic [BW-1:0]   bf_data;
  logic [1:0]      dbg_state;

  jts16_obj_zdraw dut (
    .rst(rst), .clk(clk), .hstart(hstart), .start(start),
    .busy(busy), .done(done), .late(late),
    .xpos(xpos), .addr(addr), .prio(prio), .shadow(shadow), .pal(pal),
    .hzoom(hzoom), .hflip(hflip), .backwd(backwd), .xmin(xmin), .xmax(xmax),
    .rom_ok(rom_ok), .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
    .bf_we(bf_we), .bf_addr(bf_addr), .bf_data(bf_data), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] mon_e;
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] ent(input logic [AW-1:0] a, input logic [PW-1:0] p);
    return {a, pal, shadow, prio, p};
  endfunction

  // Monitor: every buffer write is popped and compared in order
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (bf_we) begin
        check("write_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("bf_write", 32'({bf_addr, bf_data}), 32'(mon_e));
        end
      end
    end
  end

  // Driver tasks (all entered right after a falling edge)
  task automatic do_start(input logic [RAW-1:0] a, input logic [AW-1:0] x,
                          input logic [ZW-1:0] z, input logic hf, input logic bk,
                          input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    addr = a; xpos = x; hzoom = z; hflip = hf; backwd = bk; xmin = lo; xmax = hi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("rom_cs_after_start", 32'(rom_cs), 32'd1);
    check("late_after_start", 32'(late), 32'd0);
  endtask

  task automatic serve_word(input logic [RAW-1:0] ea, input logic [DW-1:0] w, input int hold);
    int n = 0;
    while (!rom_cs && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rom_cs_request", 32'(rom_cs), 32'd1);
    check("rom_addr", 32'(rom_addr), 32'(ea));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rom_cs_hold", 32'(rom_cs), 32'd1);
      check("rom_addr_hold", 32'(rom_addr), 32'(ea));
      check("no_write_in_wait", 32'(bf_we), 32'd0);
    end
    rom_ok = 1'b1;
    rom_data = w;
    @(negedge clk);
    rom_ok = 1'b0;
    rom_data = $urandom;
  endtask

  task automatic wait_idle(input logic exp_pulse);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("busy_clears", 32'(busy), 32'd0);
    check("done_at_fall", 32'(done), 32'(exp_pulse));
    @(negedge clk);
    check("done_count", 32'(done_cnt), 32'(exp_done));
    check("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_late"}, 32'(late), 32'd0);
    check({tag, "_rom_cs"}, 32'(rom_cs), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_bf_we"}, 32'(bf_we), 32'd0);
    check({tag, "_bf_addr"}, 32'(bf_addr), 32'd0);
    check({tag, "_bf_data"}, 32'(bf_data), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; hstart = 1'b0; start = 1'b0; rom_ok = 1'b0; rom_data = '0;
    xpos = '0; xmin = '0; xmax = '0; addr = '0; prio = '0; shadow = 1'b0;
    pal = '0; hzoom = '0; hflip = 1'b0; backwd = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // Forward 1:1 draw; pixel 0 transparent; second word starts with end marker
    pal = 7'h55; shadow = 1'b1; prio = 2'd2;
    for (int i = 1; i < 8; i++) exp_q.push_back(ent(AW'(9'h100 + i - 1), PW'(i)));
    do_start(18'h00100, 9'h100, 10'h200, 1'b0, 1'b0, 9'h000, 9'h1FF);
    serve_word(18'h00100, 32'h12345670, 0);
    serve_word(18'h00101, 32'hF0000000, 0);
    exp_done++;
    wait_idle(1'b1);

    // hflip: LSB-first, first pixel is the end marker
    pal = 7'h2A; shadow = 1'b0; prio = 2'd1;
    do_start(18'h00010, 9'h050, 10'h200, 1'b1, 1'b0, 9'h000, 9'h1FF);
    serve_word(18'h00010, 32'h0765432F, 0);
    exp_done++;
    wait_idle(1'b1);
    check("hflip_rom_addr_kept", 32'(rom_addr), 32'h10);

    // 2x enlarge, backward, stop at xmin
    pal = 7'h11; shadow = 1'b0; prio = 2'd3;
    exp_q.push_back(ent(9'h120, 4'h1));
    exp_q.push_back(ent(9'h11F, 4'h1));
    exp_q.push_back(ent(9'h11E, 4'h1));
    exp_q.push_back(ent(9'h11D, 4'h1));
    exp_q.push_back(ent(9'h11C, 4'h1));
    do_start(18'h00300, 9'h120, 10'h100, 1'b0, 1'b1, 9'h11C, 9'h000);
    serve_word(18'h00300, 32'h11111111, 0);
    exp_done++;
    wait_idle(1'b1);

    // Slow ROM: 20 wait cycles, then forward clip at xmax
    pal = 7'h7F; shadow = 1'b1; prio = 2'd0;
    exp_q.push_back(ent(9'h010, 4'h9));
    exp_q.push_back(ent(9'h011, 4'hA));
    exp_q.push_back(ent(9'h012, 4'hB));
    do_start(18'h01234, 9'h010, 10'h200, 1'b0, 1'b0, 9'h000, 9'h012);
    serve_word(18'h01234, 32'h9ABCDEF0, 20);
    exp_done++;
    wait_idle(1'b1);

    // hzoom=0 repeats the pixel; hstart aborts after four writes
    pal = 7'h33; shadow = 1'b0; prio = 2'd2;
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(AW'(i), 4'h1));
    do_start(18'h00200, 9'h000, 10'h000, 1'b0, 1'b0, 9'h000, 9'h1FF);
    serve_word(18'h00200, 32'h11111111, 0);
    repeat (4) @(negedge clk);
    hstart = 1'b1;
    @(negedge clk);
    hstart = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rom_cs", 32'(rom_cs), 32'd0);
    check("abort_late", 32'(late), 32'd1);
    check("abort_bf_we", 32'(bf_we), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    check("abort_done_count", 32'(done_cnt), 32'(exp_done));
    check("abort_writes_left", 32'(exp_q.size()), 32'd0);
    check("late_sticky", 32'(late), 32'd1);

    // New start clears late; reset mid-fetch clears everything at once
    do_start(18'h2AAAA, 9'h0F0, 10'h200, 1'b0, 1'b0, 9'h000, 9'h1FF);
    repeat (2) @(negedge clk);
    check("fetch_addr_before_reset", 32'(rom_addr), 32'h2AAAA);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Draw after reset, buffer address wraps past 0x1FF
    pal = 7'h01; shadow = 1'b1; prio = 2'd1;
    exp_q.push_back(ent(9'h1FE, 4'h2));
    exp_q.push_back(ent(9'h1FF, 4'h3));
    exp_q.push_back(ent(9'h000, 4'h4));
    exp_q.push_back(ent(9'h001, 4'h5));
    do_start(18'h00400, 9'h1FE, 10'h200, 1'b0, 1'b0, 9'h000, 9'h001);
    serve_word(18'h00400, 32'h2345F000, 0);
    exp_done++;
    wait_idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
